// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: shares the decode-stage register-file write port among
// NREQ write-back requesters. Round-robin grant with a starvation override;
// the grant is registered into a single write one cycle later.
// Build option: define WB_X0_FILTER_EN to drop granted GPR x0 writes
// (the request is still accepted, but reg_write stays low).
module wb_port_arbiter #(
  parameter int NREQ         = 3,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 stall,
  input  logic                 flush,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [5*NREQ-1:0]    req_rd,
  input  logic [32*NREQ-1:0]   req_data,
  input  logic [NREQ-1:0]      req_fpr,
  output logic                 reg_write,
  output logic [4:0]           write_reg,
  output logic [31:0]          write_data,
  output logic                 FPR_GPR_sel,
  output logic [NREQ-1:0]      starve_flag
);

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  logic [1:0]  rr_ptr;
  logic [3:0]  wait_cnt [NREQ];
  logic [3:0]  cnt_next [NREQ];
  logic [1:0]  rr_next;

  logic        gnt_any_p0;
  logic        starve_gnt_p0;
  logic [1:0]  gnt_idx_p0;
  logic [4:0]  sel_rd_p0;
  logic [31:0] sel_data_p0;
  logic        sel_fpr_p0;
  logic        vld_p0;

  // Saturating wait-counter increment, clamped at the starvation limit.
  function automatic logic [3:0] sat_inc(input logic [3:0] v);
    if (v >= LIMIT) return LIMIT;
    return v + 4'd1;
  endfunction

  // Modulo-NREQ pointer step used by both the RR scan and the pointer update.
  function automatic logic [1:0] wrap_add(input logic [1:0] base, input logic [2:0] off);
    logic [2:0] s;
    s = {1'b0, base} + off;
    if (s >= 3'(NREQ)) s = s - 3'(NREQ);
    return s[1:0];
  endfunction

  // Grant selection: starving ports first (lowest index), else RR scan from rr_ptr.
  always_comb begin
    gnt_any_p0    = 1'b0;
    starve_gnt_p0 = 1'b0;
    gnt_idx_p0    = 2'd0;
    if (!rst && !stall && !flush) begin
      // descending loops: the last hit written is the first in priority order
      for (int i = NREQ - 1; i >= 0; i--) begin
        if (req_valid[i] && wait_cnt[i] == LIMIT) begin
          gnt_idx_p0    = 2'(i);
          starve_gnt_p0 = 1'b1;
        end
      end
      if (starve_gnt_p0) begin
        gnt_any_p0 = 1'b1;
      end else begin
        for (int k = NREQ - 1; k >= 0; k--) begin
          if (req_valid[wrap_add(rr_ptr, 3'(k))]) begin
            gnt_idx_p0 = wrap_add(rr_ptr, 3'(k));
            gnt_any_p0 = 1'b1;
          end
        end
      end
    end
    req_ready = gnt_any_p0 ? (NREQ'(1) << gnt_idx_p0) : '0;
  end

  // Payload mux of the granted port and write-enable (optional x0 filter).
  always_comb begin
    sel_rd_p0   = req_rd[5*int'(gnt_idx_p0) +: 5];
    sel_data_p0 = req_data[32*int'(gnt_idx_p0) +: 32];
    sel_fpr_p0  = req_fpr[gnt_idx_p0];
`ifdef WB_X0_FILTER_EN
    vld_p0 = gnt_any_p0 && !(!sel_fpr_p0 && sel_rd_p0 == 5'd0);
`else
    vld_p0 = gnt_any_p0;
`endif
  end

  // Next wait counters and RR pointer; flush clears counters, stall freezes them.
  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      cnt_next[i] = wait_cnt[i];
      if (flush)
        cnt_next[i] = 4'd0;
      else if (!stall) begin
        if (!req_valid[i] || (gnt_any_p0 && gnt_idx_p0 == 2'(i)))
          cnt_next[i] = 4'd0;
        else
          cnt_next[i] = sat_inc(wait_cnt[i]);
      end
    end
    rr_next = rr_ptr;
    if (gnt_any_p0 && !starve_gnt_p0)
      rr_next = wrap_add(gnt_idx_p0, 3'd1);
  end

  // ---- stage p0 -> registered write port ----
  // Registered write, arbitration state and starvation flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_write   <= 1'b0;
      write_reg   <= 5'd0;
      write_data  <= 32'd0;
      FPR_GPR_sel <= 1'b0;
      starve_flag <= '0;
      rr_ptr      <= 2'd0;
      for (int i = 0; i < NREQ; i++) wait_cnt[i] <= 4'd0;
    end else begin
      reg_write <= vld_p0;
      if (vld_p0) begin
        write_reg   <= sel_rd_p0;
        write_data  <= sel_data_p0;
        FPR_GPR_sel <= sel_fpr_p0;
      end
      rr_ptr <= rr_next;
      for (int i = 0; i < NREQ; i++) begin
        wait_cnt[i]    <= cnt_next[i];
        starve_flag[i] <= (cnt_next[i] == LIMIT);
      end
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed bench for wb_port_arbiter: default instance (STARVE_LIMIT=4) and a
// STARVE_LIMIT=2 instance share the request inputs.
module tb_wb_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  req_valid = '0;
  logic [14:0] req_rd = '0;
  logic [95:0] req_data = '0;
  logic [2:0]  req_fpr = '0;

  logic [2:0]  a_ready, b_ready, a_starve, b_starve;
  logic        a_reg_write, b_reg_write, a_fpr, b_fpr;
  logic [4:0]  a_write_reg, b_write_reg;
  logic [31:0] a_write_data, b_write_data;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_port_arbiter #(.NREQ(3), .STARVE_LIMIT(4)) dut_a (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .req_valid(req_valid), .req_ready(a_ready), .req_rd(req_rd),
    .req_data(req_data), .req_fpr(req_fpr), .reg_write(a_reg_write),
    .write_reg(a_write_reg), .write_data(a_write_data),
    .FPR_GPR_sel(a_fpr), .starve_flag(a_starve)
  );

  wb_port_arbiter #(.NREQ(3), .STARVE_LIMIT(2)) dut_b (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .req_valid(req_valid), .req_ready(b_ready), .req_rd(req_rd),
    .req_data(req_data), .req_fpr(req_fpr), .reg_write(b_reg_write),
    .write_reg(b_write_reg), .write_data(b_write_data),
    .FPR_GPR_sel(b_fpr), .starve_flag(b_starve)
  );

  // Leaves the bench 1 time unit after a rising edge with reset released.
  task automatic do_reset();
    stall = 1'b0; flush = 1'b0; req_valid = '0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    req_valid = 3'b010; req_rd[9:5] = 5'd9; req_data[63:32] = 32'hCAFE_0001; req_fpr = 3'b010;
    @(posedge clk); #1;
    #3;
    req_valid = 3'b111;
    rst = 1'b1;
    #1;
    checks++; if (a_reg_write !== 1'b0) begin errors++; $display("FAIL reset_reg_write: got %b expected 0", a_reg_write); end
    checks++; if (a_write_reg !== 5'd0) begin errors++; $display("FAIL reset_write_reg: got %0d expected 0", a_write_reg); end
    checks++; if (a_write_data !== 32'd0) begin errors++; $display("FAIL reset_write_data: got %h expected 0", a_write_data); end
    checks++; if (a_fpr !== 1'b0) begin errors++; $display("FAIL reset_fpr_sel: got %b expected 0", a_fpr); end
    checks++; if (a_starve !== 3'b000) begin errors++; $display("FAIL reset_starve_flag: got %b expected 000", a_starve); end
    checks++; if (a_ready !== 3'b000) begin errors++; $display("FAIL reset_ready: got %b expected 000", a_ready); end
    @(posedge clk); #1;
    checks++; if (a_ready !== 3'b000) begin errors++; $display("FAIL reset_ready_held: got %b expected 000", a_ready); end
    rst = 1'b0; req_valid = '0; req_fpr = '0;
  endtask

  task automatic test_single();
    do_reset();
    req_valid = 3'b010; req_rd[9:5] = 5'd5; req_data[63:32] = 32'hDEAD_BEEF; req_fpr = 3'b000;
    #1;
    checks++; if (a_ready !== 3'b010) begin errors++; $display("FAIL single_ready: got %b expected 010", a_ready); end
    @(posedge clk); #1;
    req_valid = '0;
    checks++; if (a_reg_write !== 1'b1) begin errors++; $display("FAIL single_reg_write: got %b expected 1", a_reg_write); end
    checks++; if (a_write_reg !== 5'd5) begin errors++; $display("FAIL single_write_reg: got %0d expected 5", a_write_reg); end
    checks++; if (a_write_data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL single_write_data: got %h expected deadbeef", a_write_data); end
    checks++; if (a_fpr !== 1'b0) begin errors++; $display("FAIL single_fpr_sel: got %b expected 0", a_fpr); end
    @(posedge clk); #1;
    checks++; if (a_reg_write !== 1'b0) begin errors++; $display("FAIL single_reg_write_n2: got %b expected 0", a_reg_write); end
    checks++; if (a_write_reg !== 5'd5) begin errors++; $display("FAIL single_write_reg_hold: got %0d expected 5", a_write_reg); end
  endtask

  task automatic test_round_robin();
    logic [2:0] exp_rdy;
    logic [4:0] exp_rd;
    do_reset();
    req_rd = {5'd12, 5'd11, 5'd10};
    req_data = {32'h2222_2222, 32'h1111_1111, 32'h0000_0000};
    req_fpr = '0;
    req_valid = 3'b111;
    for (int k = 0; k < 6; k++) begin
      exp_rdy = 3'(1 << (k % 3));
      exp_rd = 5'(10 + (k % 3));
      #1;
      checks++; if (a_ready !== exp_rdy) begin errors++; $display("FAIL rr_ready[%0d]: got %b expected %b", k, a_ready, exp_rdy); end
      @(posedge clk); #1;
      checks++; if (a_write_reg !== exp_rd) begin errors++; $display("FAIL rr_write_reg[%0d]: got %0d expected %0d", k, a_write_reg, exp_rd); end
      checks++; if (a_starve !== 3'b000) begin errors++; $display("FAIL rr_starve_flag[%0d]: got %b expected 000", k, a_starve); end
    end
    req_valid = '0;
  endtask

  task automatic test_starvation();
    logic [2:0] vld_v [6] = '{3'b111, 3'b111, 3'b111, 3'b111, 3'b000, 3'b111};
    logic [2:0] exp_rdy [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b000, 3'b100};
    logic [2:0] exp_flag [6] = '{3'b000, 3'b100, 3'b001, 3'b010, 3'b000, 3'b000};
    do_reset();
    req_rd = {5'd22, 5'd21, 5'd20};
    req_fpr = '0;
    for (int k = 0; k < 6; k++) begin
      req_valid = vld_v[k];
      #1;
      checks++; if (b_ready !== exp_rdy[k]) begin errors++; $display("FAIL starve_ready[%0d]: got %b expected %b", k, b_ready, exp_rdy[k]); end
      @(posedge clk); #1;
      checks++; if (b_starve !== exp_flag[k]) begin errors++; $display("FAIL starve_flag[%0d]: got %b expected %b", k, b_starve, exp_flag[k]); end
    end
    req_valid = '0;
  endtask

  task automatic test_stall();
    do_reset();
    req_rd[14:10] = 5'd7; req_data[95:64] = 32'h1234_5678; req_fpr = 3'b100;
    req_valid = 3'b100;
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++; if (a_ready !== 3'b000) begin errors++; $display("FAIL stall_ready[%0d]: got %b expected 000", k, a_ready); end
      @(posedge clk); #1;
      checks++; if (a_reg_write !== 1'b0) begin errors++; $display("FAIL stall_reg_write[%0d]: got %b expected 0", k, a_reg_write); end
    end
    stall = 1'b0;
    #1;
    checks++; if (a_ready !== 3'b100) begin errors++; $display("FAIL stall_release_ready: got %b expected 100", a_ready); end
    @(posedge clk); #1;
    req_valid = '0;
    checks++; if (a_reg_write !== 1'b1) begin errors++; $display("FAIL stall_reg_write_after: got %b expected 1", a_reg_write); end
    checks++; if (a_fpr !== 1'b1) begin errors++; $display("FAIL stall_fpr_sel: got %b expected 1", a_fpr); end
    checks++; if (a_write_reg !== 5'd7) begin errors++; $display("FAIL stall_write_reg: got %0d expected 7", a_write_reg); end
    checks++; if (a_write_data !== 32'h1234_5678) begin errors++; $display("FAIL stall_write_data: got %h expected 12345678", a_write_data); end
    req_fpr = '0;
  endtask

  task automatic test_x0_and_flush();
    logic        exp_we;
    logic [31:0] exp_data;
`ifdef WB_X0_FILTER_EN
    exp_we = 1'b0; exp_data = 32'd0;
`else
    exp_we = 1'b1; exp_data = 32'd1;
`endif
    do_reset();
    req_rd[4:0] = 5'd0; req_data[31:0] = 32'd1; req_fpr = 3'b000;
    req_valid = 3'b001;
    #1;
    checks++; if (a_ready !== 3'b001) begin errors++; $display("FAIL x0_ready: got %b expected 001", a_ready); end
    @(posedge clk); #1;
    checks++; if (a_reg_write !== exp_we) begin errors++; $display("FAIL x0_reg_write: got %b expected %b", a_reg_write, exp_we); end
    checks++; if (a_write_data !== exp_data) begin errors++; $display("FAIL x0_write_data: got %h expected %h", a_write_data, exp_data); end
    flush = 1'b1;
    #1;
    checks++; if (a_ready !== 3'b000) begin errors++; $display("FAIL flush_ready: got %b expected 000", a_ready); end
    @(posedge clk); #1;
    checks++; if (a_reg_write !== 1'b0) begin errors++; $display("FAIL flush_reg_write: got %b expected 0", a_reg_write); end
    flush = 1'b0;
    stall = 1'b1;
    req_rd[4:0] = 5'd3;
    flush = 1'b1;
    #1;
    checks++; if (a_ready !== 3'b000) begin errors++; $display("FAIL flush_stall_ready: got %b expected 000", a_ready); end
    @(posedge clk); #1;
    stall = 1'b0; flush = 1'b0;
    #1;
    checks++; if (a_ready !== 3'b001) begin errors++; $display("FAIL post_flush_ready: got %b expected 001", a_ready); end
    @(posedge clk); #1;
    req_valid = '0;
    checks++; if (a_write_reg !== 5'd3) begin errors++; $display("FAIL post_flush_write_reg: got %0d expected 3", a_write_reg); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_starvation();
    test_stall();
    test_x0_and_flush();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
